// File: rtl/seg7_scan_driver_if.sv
// Display-update bus between the producer (ALU result path) and the
// 7-segment scan driver, plus the pin-side outputs of the driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = 3
) ();
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp;
    logic [NUM_DIGITS-1:0]     blank;
    logic                      lz_en;
    logic [6:0]                a_to_g;
    logic                      dp_n;
    logic [NUM_DIGITS-1:0]     an;
    logic [IDX_W-1:0]          scan_idx;

    modport master (
        output load, value, dp, blank, lz_en,
        input  a_to_g, dp_n, an, scan_idx
    );

    modport slave (
        input  load, value, dp, blank, lz_en,
        output a_to_g, dp_n, an, scan_idx
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with shadowed
// value/dp/blank/lz_en, programmable dwell per digit, hex decode,
// leading-zero suppression and per-digit blanking. Outputs are registered.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int IDX_W       = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_driver_if.slave  bus
);
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] sh_val;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic                    sh_lz;

    logic [PRE_W-1:0]        pre, pre_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;

    logic [NUM_DIGITS-1:0]   supp;
    logic                    lead;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_blank, cur_supp;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [6:0]              seg_nxt;
    logic                    dpn_nxt;

    logic [6:0]              seg_q;
    logic                    dpn_q;
    logic [NUM_DIGITS-1:0]   an_q;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Prescaler wrap advances the scan index; index wraps at the last digit.
    always_comb begin
        pre_nxt = pre + 1'b1;
        idx_nxt = idx;
        if (pre == PRE_LAST) begin
            pre_nxt = '0;
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // Leading-zero mask: walk from the top digit down, suppressing zeros
    // until the first nonzero nibble; digit 0 always shows.
    always_comb begin
        supp = '0;
        lead = sh_lz;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (sh_val[4*(NUM_DIGITS-1-k) +: 4] == 4'h0) begin
                supp[NUM_DIGITS-1-k] = lead && (k != NUM_DIGITS - 1);
            end else begin
                lead = 1'b0;
            end
        end
    end

    // Select the current digit's data and form the next output pattern.
    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        cur_supp  = 1'b0;
        an_nxt    = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = sh_val[4*i +: 4];
                cur_dp    = sh_dp[i];
                cur_blank = sh_blank[i];
                cur_supp  = supp[i];
                an_nxt[i] = 1'b0;
            end
        end
        seg_nxt = (cur_blank || cur_supp) ? '1 : hex2seg(cur_nib);
        dpn_nxt = cur_blank ? 1'b1 : ~cur_dp;
    end

    // Shadow capture on load; a load coinciding with output update takes
    // effect on the following edge since outputs use the pre-edge shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_val   <= '0;
            sh_dp    <= '0;
            sh_blank <= '1;
            sh_lz    <= 1'b0;
        end else if (bus.load) begin
            sh_val   <= bus.value;
            sh_dp    <= bus.dp;
            sh_blank <= bus.blank;
            sh_lz    <= bus.lz_en;
        end
    end

    // Scan timing and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre   <= '0;
            idx   <= '0;
            an_q  <= '1;
            seg_q <= '1;
            dpn_q <= 1'b1;
        end else begin
            pre   <= pre_nxt;
            idx   <= idx_nxt;
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
            dpn_q <= dpn_nxt;
        end
    end

    assign bus.a_to_g   = seg_q;
    assign bus.dp_n     = dpn_q;
    assign bus.an       = an_q;
    assign bus.scan_idx = idx;
endmodule
